dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the core load/store port and a host loader/debug port.
//  Two-requester round-robin arbitration, one access in flight at a time, fixed read latency.
//  Bounds-checks addresses against DEPTH. Sits between microprocessor-class cores and the dmem array.
// PARAMETERS
//  ADDR_W   8  address width, both requesters and memory
//  DATA_W   8  data width
//  DEPTH    3  number of implemented memory words; addr >= DEPTH is out of range
//  MEM_LAT  1  memory read latency in cycles, legal range 1..4
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  c_req     in   1       core request; hold with c_we/c_addr/c_wdata stable until c_gnt
//  c_we      in   1       1 = write, 0 = read
//  c_addr    in   ADDR_W  core address
//  c_wdata   in   DATA_W  core write data
//  c_gnt     out  1       one-cycle pulse: core command issued this cycle
//  c_rvalid  out  1       one-cycle pulse: c_rdata valid
//  c_rdata   out  DATA_W  core read data
//  c_err     out  1       one-cycle pulse with gnt when c_addr >= DEPTH
//  h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata, h_err   host port, same widths/rules as core
//  m_en      out  1       memory command strobe
//  m_we      out  1       memory write enable, qualified by m_en
//  m_addr    out  ADDR_W  memory address
//  m_wdata   out  DATA_W  memory write data
//  m_rdata   in   DATA_W  memory read data, valid MEM_LAT cycles after m_en read
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr pointer=HOST (core wins first tie), lat counter=0;
//   all gnt/rvalid/err/m_en/m_we = 0, rdata outputs = 0, m_addr/m_wdata = 0. Immediate on assertion.
//  Reset mid-read: outstanding read discarded; no rvalid after rst_n deasserts.
//  States: IDLE -> (read granted) RD_WAIT -> RESP -> IDLE. Writes never leave IDLE.
//  IDLE: if any req, pick winner combinationally; in same cycle T: winner gnt=1, m_en=1, m_we/m_addr/m_wdata
//   = winner's command. Loser sees gnt=0 and keeps req asserted.
//  Arbitration: single req -> granted. Both req -> grant requester != rr pointer; pointer := winner on every gnt.
//  Write: completes at cycle T; FSM stays IDLE; next grant possible at T+1 (back-to-back writes, 1/cycle).
//  Read: owner latched; RD_WAIT counts MEM_LAT-1 cycles (skipped when MEM_LAT=1) into RESP.
//   RESP at cycle T+MEM_LAT: owner rvalid=1, owner rdata=m_rdata (registered capture, held until next rvalid).
//   No grants during RD_WAIT/RESP; next grant earliest T+MEM_LAT+1. Read occupancy = MEM_LAT+1 cycles.
//  Out of range (addr >= DEPTH): gnt and err pulse at T, m_en=0 (no memory access).
//   Write dropped. Read still follows RD_WAIT/RESP timing; rvalid pulses with rdata=0.
//  gnt, err, m_* are combinational from state+req; rvalid, rdata registered.
//  Requester dropping req before gnt: allowed, no access issued. Changing payload while req high and
//   not granted: protocol violation, behaviour undefined (assertion in bench).
//  rvalid never asserted on the non-owner port; gnt never to both ports in one cycle.
// STRUCTURE
//  Package dmem_pkg: ADDR_W/DATA_W defaults, state enum {IDLE, RD_WAIT, RESP}, requester id enum {CORE, HOST}.
//  Sub-module rr_arb2: 2-way round-robin picker (req[1:0], ptr, en -> gnt_onehot, next_ptr).
//  Top holds FSM, latency counter, owner latch, address range check, response capture.
// TESTING
//  Memory preloaded 0:0xF6, 1:0x0A, 2:0x02; MEM_LAT=1 unless stated.
//  1 Core read addr 1 alone -> c_gnt at T, c_rvalid at T+1 with c_rdata=0x0A; h_* stay 0.
//  2 Core+host read same cycle after reset -> core granted first (0xF6 from addr 0), host granted at T+2;
//    repeat both pending -> grants alternate C,H,C,H.
//  3 Host writes 0x55 to addr 2 on 3 consecutive cycles then core reads 2 -> h_gnt each cycle, c_rdata=0x55.
//  4 Core read addr 3 -> c_gnt+c_err at T, m_en=0, c_rvalid at T+1 with c_rdata=0x00; host write addr 5 dropped.
//  5 MEM_LAT=3: host read addr 0 -> h_rvalid at T+3 with 0xF6; core req held from T+1 granted at T+4.
//  6 rst_n pulsed low at T+1 of MEM_LAT=3 read -> outputs 0 immediately; no rvalid; next req served from IDLE.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  typedef enum logic {CORE = 1'b0, HOST = 1'b1} req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; bit 0 = core, bit 1 = host
module rr_arb2
  import dmem_pkg::*;
(
  input  logic    [1:0] req,
  input  req_id_t       ptr,
  input  logic          en,
  output logic    [1:0] gnt_onehot,
  output req_id_t       next_ptr
);

  always_comb begin
    gnt_onehot = 2'b00;
    if (en) begin
      // On a tie the requester that did not win last time goes first.
      if (req == 2'b11) gnt_onehot = (ptr == HOST) ? 2'b01 : 2'b10;
      else              gnt_onehot = req;
    end
    if (gnt_onehot[1])      next_ptr = HOST;
    else if (gnt_onehot[0]) next_ptr = CORE;
    else                    next_ptr = ptr;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter in front of the single-port data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t      state;
  req_id_t     ptr, next_ptr, owner, win_id, cap_owner;
  logic        owner_oor;
  logic [1:0]  lat_cnt;
  logic [1:0]  gnt;
  logic        arb_en, any_gnt, win_we, win_oor, c_oor, h_oor;
  logic        lat_done, cap, cap_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata, cap_data;

  // Grants are also held off while reset is asserted so outputs drop at once.
  assign arb_en = (state == IDLE) && rst_n;

  rr_arb2 u_rr (
    .req        ({h_req, c_req}),
    .ptr        (ptr),
    .en         (arb_en),
    .gnt_onehot (gnt),
    .next_ptr   (next_ptr)
  );

  assign c_oor     = c_addr >= ADDR_W'(DEPTH);
  assign h_oor     = h_addr >= ADDR_W'(DEPTH);
  assign any_gnt   = |gnt;
  assign win_id    = gnt[1] ? HOST : CORE;
  assign win_we    = gnt[1] ? h_we    : c_we;
  assign win_addr  = gnt[1] ? h_addr  : c_addr;
  assign win_wdata = gnt[1] ? h_wdata : c_wdata;
  assign win_oor   = gnt[1] ? h_oor   : c_oor;

  assign c_gnt   = gnt[0];
  assign h_gnt   = gnt[1];
  assign c_err   = gnt[0] & c_oor;
  assign h_err   = gnt[1] & h_oor;
  assign m_en    = any_gnt & ~win_oor;
  assign m_we    = m_en & win_we;
  assign m_addr  = m_en ? win_addr : '0;
  assign m_wdata = m_we ? win_wdata : '0;

  // m_rdata is sampled on the edge that enters RESP; with MEM_LAT=1 that is the grant edge.
  assign lat_done  = (lat_cnt == 2'(MEM_LAT - 2));
  assign cap       = ((state == IDLE) && any_gnt && !win_we && (MEM_LAT == 1)) ||
                     ((state == RD_WAIT) && lat_done);
  assign cap_owner = (state == IDLE) ? win_id  : owner;
  assign cap_oor   = (state == IDLE) ? win_oor : owner_oor;
  assign cap_data  = cap_oor ? '0 : m_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= HOST;
      owner     <= CORE;
      owner_oor <= 1'b0;
      lat_cnt   <= 2'd0;
      c_rvalid  <= 1'b0;
      h_rvalid  <= 1'b0;
      c_rdata   <= '0;
      h_rdata   <= '0;
    end else begin
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      ptr      <= next_ptr;
      if (cap) begin
        if (cap_owner == HOST) begin
          h_rvalid <= 1'b1;
          h_rdata  <= cap_data;
        end else begin
          c_rvalid <= 1'b1;
          c_rdata  <= cap_data;
        end
      end
      case (state)
        IDLE: begin
          if (any_gnt && !win_we) begin
            owner     <= win_id;
            owner_oor <= win_oor;
            lat_cnt   <= 2'd0;
            state     <= (MEM_LAT == 1) ? RESP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_done) state <= RESP;
          else          lat_cnt <= lat_cnt + 2'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vectors for dmem_arbiter at MEM_LAT 1 and 3
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MEM_LAT = 1 instance
  logic       rst_n;
  logic       c_req, c_we, h_req, h_we;
  logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
  logic       c_gnt, c_rvalid, c_err, h_gnt, h_rvalid, h_err;
  logic [7:0] c_rdata, h_rdata;
  logic       m_en, m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;

  // MEM_LAT = 3 instance
  logic       rst3_n;
  logic       c3_req, c3_we, h3_req, h3_we;
  logic [7:0] c3_addr, c3_wdata, h3_addr, h3_wdata;
  logic       c3_gnt, c3_rvalid, c3_err, h3_gnt, h3_rvalid, h3_err;
  logic [7:0] c3_rdata, h3_rdata;
  logic       m3_en, m3_we;
  logic [7:0] m3_addr, m3_wdata, m3_rdata;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(3), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(3), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .c_req(c3_req), .c_we(c3_we), .c_addr(c3_addr), .c_wdata(c3_wdata),
    .c_gnt(c3_gnt), .c_rvalid(c3_rvalid), .c_rdata(c3_rdata), .c_err(c3_err),
    .h_req(h3_req), .h_we(h3_we), .h_addr(h3_addr), .h_wdata(h3_wdata),
    .h_gnt(h3_gnt), .h_rvalid(h3_rvalid), .h_rdata(h3_rdata), .h_err(h3_err),
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_rdata(m3_rdata)
  );

  // Memory models: latency 1 is an asynchronous read captured by the arbiter,
  // latency 3 adds two register stages in front of it.
  logic [7:0] mem  [256];
  logic [7:0] mem3 [256];
  logic [7:0] dly0, dly1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mem3[i] = 8'h00;
    end
    mem[0]  = 8'hF6; mem[1]  = 8'h0A; mem[2]  = 8'h02;
    mem3[0] = 8'hF6; mem3[1] = 8'h0A; mem3[2] = 8'h02;
    dly0 = 8'h00;
    dly1 = 8'h00;
  end

  assign m_rdata  = mem[m_addr];
  assign m3_rdata = dly1;

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m3_en && m3_we) mem3[m3_addr] <= m3_wdata;
    dly0 <= (m3_en && !m3_we) ? mem3[m3_addr] : 8'h00;
    dly1 <= dly0;
  end

  // Payload of a pending, ungranted request must not change.
  logic        c_pend = 1'b0, h_pend = 1'b0;
  logic [16:0] c_cmd_q = '0, h_cmd_q = '0;
  always @(negedge clk) begin
    if (c_pend && c_req && ({c_we, c_addr, c_wdata} != c_cmd_q)) begin
      $display("FAIL protocol_core: payload %h changed from %h", {c_we, c_addr, c_wdata}, c_cmd_q);
      errors++;
    end
    if (h_pend && h_req && ({h_we, h_addr, h_wdata} != h_cmd_q)) begin
      $display("FAIL protocol_host: payload %h changed from %h", {h_we, h_addr, h_wdata}, h_cmd_q);
      errors++;
    end
    c_pend  = c_req && !c_gnt;
    h_pend  = h_req && !h_gnt;
    c_cmd_q = {c_we, c_addr, c_wdata};
    h_cmd_q = {h_we, h_addr, h_wdata};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       cr, cw;
    logic [7:0] ca, cd;
    logic       hr, hw;
    logic [7:0] ha, hd;
    logic       cg, hg, ce, he, men, mwe;
    logic [7:0] maddr;
    logic       cv, hv;
    logic [7:0] crd, hrd;
  } vec_t;

  vec_t vecs[24];

  initial begin
    // cr cw ca cd | hr hw ha hd | cg hg ce he men mwe maddr | cv hv crd hrd
    vecs[0]  = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 0,0,8'h00,8'h00};
    vecs[1]  = '{1,0,8'h0,8'h0, 1,0,8'h1,8'h00, 1,0,0,0,1,0,8'h0, 0,0,8'h00,8'h00};
    vecs[2]  = '{0,0,8'h0,8'h0, 1,0,8'h1,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'hF6,8'h00};
    vecs[3]  = '{0,0,8'h0,8'h0, 1,0,8'h1,8'h00, 0,1,0,0,1,0,8'h1, 0,0,8'hF6,8'h00};
    vecs[4]  = '{1,0,8'h2,8'h0, 1,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 0,1,8'hF6,8'h0A};
    vecs[5]  = '{1,0,8'h2,8'h0, 1,0,8'h0,8'h00, 1,0,0,0,1,0,8'h2, 0,0,8'hF6,8'h0A};
    vecs[6]  = '{1,0,8'h1,8'h0, 1,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'h02,8'h0A};
    vecs[7]  = '{1,0,8'h1,8'h0, 1,0,8'h0,8'h00, 0,1,0,0,1,0,8'h0, 0,0,8'h02,8'h0A};
    vecs[8]  = '{1,0,8'h1,8'h0, 1,0,8'h2,8'h00, 0,0,0,0,0,0,8'h0, 0,1,8'h02,8'hF6};
    vecs[9]  = '{1,0,8'h1,8'h0, 1,0,8'h2,8'h00, 1,0,0,0,1,0,8'h1, 0,0,8'h02,8'hF6};
    vecs[10] = '{0,0,8'h0,8'h0, 1,0,8'h2,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'h0A,8'hF6};
    vecs[11] = '{0,0,8'h0,8'h0, 1,0,8'h2,8'h00, 0,1,0,0,1,0,8'h2, 0,0,8'h0A,8'hF6};
    vecs[12] = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 0,1,8'h0A,8'h02};
    vecs[13] = '{0,0,8'h0,8'h0, 1,1,8'h2,8'h55, 0,1,0,0,1,1,8'h2, 0,0,8'h0A,8'h02};
    vecs[14] = '{0,0,8'h0,8'h0, 1,1,8'h2,8'h55, 0,1,0,0,1,1,8'h2, 0,0,8'h0A,8'h02};
    vecs[15] = '{0,0,8'h0,8'h0, 1,1,8'h2,8'h55, 0,1,0,0,1,1,8'h2, 0,0,8'h0A,8'h02};
    vecs[16] = '{1,0,8'h2,8'h0, 0,0,8'h0,8'h00, 1,0,0,0,1,0,8'h2, 0,0,8'h0A,8'h02};
    vecs[17] = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'h55,8'h02};
    vecs[18] = '{1,0,8'h3,8'h0, 0,0,8'h0,8'h00, 1,0,1,0,0,0,8'h0, 0,0,8'h55,8'h02};
    vecs[19] = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'h00,8'h02};
    vecs[20] = '{0,0,8'h0,8'h0, 1,1,8'h5,8'h77, 0,1,0,1,0,0,8'h0, 0,0,8'h00,8'h02};
    vecs[21] = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 0,0,8'h00,8'h02};
    vecs[22] = '{1,0,8'h1,8'h0, 0,0,8'h0,8'h00, 1,0,0,0,1,0,8'h1, 0,0,8'h00,8'h02};
    vecs[23] = '{0,0,8'h0,8'h0, 0,0,8'h0,8'h00, 0,0,0,0,0,0,8'h0, 1,0,8'h0A,8'h02};

    rst_n = 1'b0; rst3_n = 1'b0;
    {c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata} = '0;
    {c3_req, c3_we, c3_addr, c3_wdata, h3_req, h3_we, h3_addr, h3_wdata} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      c_req = vecs[i].cr; c_we = vecs[i].cw; c_addr = vecs[i].ca; c_wdata = vecs[i].cd;
      h_req = vecs[i].hr; h_we = vecs[i].hw; h_addr = vecs[i].ha; h_wdata = vecs[i].hd;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {c_gnt, h_gnt, c_err, h_err, m_en, m_en & m_we, (m_en ? m_addr : 8'h00),
           c_rvalid, h_rvalid, c_rdata, h_rdata},
          {vecs[i].cg, vecs[i].hg, vecs[i].ce, vecs[i].he, vecs[i].men, vecs[i].mwe,
           vecs[i].maddr, vecs[i].cv, vecs[i].hv, vecs[i].crd, vecs[i].hrd});
    end
    chk("mem2_written", {24'h0, mem[2]}, 32'h55);
    chk("mem5_untouched", {24'h0, mem[5]}, 32'h00);

    // MEM_LAT=3: host read at T, core waits from T+1 and is granted at T+4.
    @(posedge clk); #1;
    h3_req = 1'b1; h3_addr = 8'h0;
    @(negedge clk);
    chk("l3_h_gnt_T", {29'h0, h3_gnt, m3_en, c3_gnt}, 32'b110);
    @(posedge clk); #1;
    h3_req = 1'b0; c3_req = 1'b1; c3_addr = 8'h1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("l3_wait_T+%0d", k), {22'h0, c3_gnt, h3_rvalid, h3_rdata},
          (k == 3) ? 32'h1F6 : 32'h0);
    end
    @(negedge clk);
    chk("l3_c_gnt_T+4", {22'h0, c3_gnt, m3_en, m3_addr}, 32'h301);
    @(posedge clk); #1;
    c3_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("l3_c_resp_%0d", k), {23'h0, c3_rvalid, c3_rdata},
          (k == 3) ? 32'h10A : {24'h0, 8'h00});
    end

    // Reset pulsed during an outstanding MEM_LAT=3 read.
    @(posedge clk); #1;
    h3_req = 1'b1; h3_addr = 8'h2;
    @(negedge clk);
    chk("rst_h_gnt", {31'h0, h3_gnt}, 32'h1);
    @(posedge clk); #1;
    h3_req = 1'b0; c3_req = 1'b1; c3_addr = 8'h2;
    rst3_n = 1'b0;
    #1;
    chk("rst_immediate", {13'h0, c3_gnt, h3_gnt, m3_en, c3_rvalid, h3_rvalid, c3_rdata, h3_rdata}, 32'h0);
    @(negedge clk);
    chk("rst_held", {13'h0, c3_gnt, h3_gnt, m3_en, c3_rvalid, h3_rvalid, c3_rdata, h3_rdata}, 32'h0);
    @(posedge clk); #1;
    rst3_n = 1'b1; c3_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rvalid_%0d", k), {30'h0, c3_rvalid, h3_rvalid}, 32'h0);
    end
    @(posedge clk); #1;
    c3_req = 1'b1; c3_addr = 8'h2;
    @(negedge clk);
    chk("rst_after_c_gnt", {31'h0, c3_gnt}, 32'h1);
    @(posedge clk); #1;
    c3_req = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("rst_after_c_resp", {23'h0, c3_rvalid, c3_rdata}, 32'h102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
